// File: rtl/led_toggler_n.sv
// led_toggler_n: per-channel debounced buttons driving LEDs in toggle/momentary/blink/off modes.
// Define LED_TOGGLER_SYNC_EN to insert a two-flop synchroniser on every button input.
module led_toggler_n #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_HALF      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) < 1 ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  logic [CHANNELS-1:0] smp;
  logic [CHANNELS-1:0] db_q, db_d, tog_q, tog_d, press_q, press_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
`ifdef LED_TOGGLER_SYNC_EN
  logic [CHANNELS-1:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  assign smp = s2_q;
`else
  assign smp = btn;
`endif
  always_comb begin
    db_d    = db_q;
    tog_d   = tog_q;
    press_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (smp[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]    = smp[i];
          press_d[i] = smp[i];
          // toggle state only advances in the toggle and blink modes
          tog_d[i]   = tog_q[i] ^ (smp[i] & ~mode[0]);
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
    phase_d = phase_q ^ (bcnt_q == BLINK_LAST);
    led     = mode == 2'b00 ? tog_q :
              mode == 2'b01 ? db_q :
              mode == 2'b10 ? tog_q & {CHANNELS{phase_q}} : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_q    <= '0;
      tog_q   <= '0;
      press_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      db_q    <= db_d;
      tog_q   <= tog_d;
      press_q <= press_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  assign press = press_q;
endmodule

// File: tb/tb_led_toggler_n.sv
// tb_led_toggler_n: scoreboard bench for led_toggler_n; expectations queued per driven cycle.
module tb_led_toggler_n;
`ifdef LED_TOGGLER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int L = LAT + 3;
  logic       clk, rst_n;
  logic [3:0] btn, led, press;
  logic [1:0] mode;
  logic [7:0] exp_q [$];
  logic [7:0] e;
  int n_cmp, n_bad, edges;

  led_toggler_n #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .BLINK_HALF(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .mode(mode), .led(led), .press(press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input logic [3:0] b, input logic [1:0] m);
    btn  = b;
    mode = m;
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    btn   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 4'hF;
    mode  = 2'b00;
    repeat (3) begin
      @(negedge clk);
      exp_q.push_back(8'h00);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL reset_hold: led/press got %b/%b expected %b/%b", led, press, e[7:4], e[3:0]);
      end
    end
    rst_n = 1'b1;
    edges = 0;
    for (int j = 0; j < L + 2; j++) begin
      exp_q.push_back({(j >= L) ? 4'hF : 4'h0, (j == L) ? 4'hF : 4'h0});
      tick(4'hF, 2'b00);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL reset_release cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
    do_reset();
  endtask

  task automatic test_toggle();
    logic t = 1'b0;
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 10; j++) begin
        if (p % 2 == 0 && j == L) t = ~t;
        exp_q.push_back({3'b000, t, 3'b000, (p % 2 == 0 && j == L)});
        tick((p % 2 == 0) ? 4'b0001 : 4'b0000, 2'b00);
        e = exp_q.pop_front();
        n_cmp++;
        if ({led, press} !== e) begin
          n_bad++;
          $display("FAIL toggle p%0d cyc%0d: led/press got %b/%b expected %b/%b", p, j, led, press, e[7:4], e[3:0]);
        end
      end
  endtask

  task automatic test_glitch();
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(8'h00);
      tick((j < 3) ? 4'b0010 : 4'b0000, 2'b00);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL glitch cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
    for (int j = 0; j < 12; j++) begin
      exp_q.push_back({(j >= L) ? 4'b0010 : 4'b0000, (j == L) ? 4'b0010 : 4'b0000});
      tick((j <= L) ? 4'b0010 : 4'b0000, 2'b00);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL glitch_accept cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
  endtask

  task automatic test_momentary();
    for (int j = 0; j < 14; j++) begin
      exp_q.push_back({(j >= L && j < 6 + L) ? 4'b0100 : 4'b0000, (j == L) ? 4'b0100 : 4'b0000});
      tick((j < 6) ? 4'b0100 : 4'b0000, 2'b01);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL momentary cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
    exp_q.push_back(8'b0010_0000);
    tick(4'b0000, 2'b00);
    e = exp_q.pop_front();
    n_cmp++;
    if ({led, press} !== e) begin
      n_bad++;
      $display("FAIL momentary_tog_kept: led/press got %b/%b expected %b/%b", led, press, e[7:4], e[3:0]);
    end
  endtask

  task automatic test_blink();
    logic       t3 = 1'b0;
    logic       ph;
    logic [3:0] hit;
    for (int j = 0; j < 48; j++) begin
      hit = (j == L || j == 24 + L) ? 4'b1000 : 4'b0000;
      if (hit[3]) t3 = ~t3;
      ph = ((edges + 1) / 8) % 2 == 1;
      exp_q.push_back({{t3, 3'b010} & {4{ph}}, hit});
      tick((j <= L || (j >= 24 && j <= 24 + L)) ? 4'b1000 : 4'b0000, 2'b10);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL blink cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
    mode = 2'b11;
    #1;
    n_cmp++;
    if (led !== 4'b0000) begin
      n_bad++;
      $display("FAIL off_immediate: led got %b expected 0000", led);
    end
    for (int j = 0; j < 2 * L + 3; j++) begin
      exp_q.push_back({4'b0000, (j == L) ? 4'b0001 : 4'b0000});
      tick((j <= L) ? 4'b0001 : 4'b0000, 2'b11);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL off_press cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
    exp_q.push_back(8'b0010_0000);
    tick(4'b0000, 2'b00);
    e = exp_q.pop_front();
    n_cmp++;
    if ({led, press} !== e) begin
      n_bad++;
      $display("FAIL off_tog_frozen: led/press got %b/%b expected %b/%b", led, press, e[7:4], e[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < LAT + 2; j++) begin
      exp_q.push_back(8'b0010_0000);
      tick(4'b0001, 2'b00);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL mid_pre cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({led, press} !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_async: led/press got %b/%b expected 0000/0000", led, press);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    for (int j = 0; j < L + 2; j++) begin
      exp_q.push_back({(j >= L) ? 4'b0001 : 4'b0000, (j == L) ? 4'b0001 : 4'b0000});
      tick(4'b0001, 2'b00);
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, press} !== e) begin
        n_bad++;
        $display("FAIL mid_post cyc%0d: led/press got %b/%b expected %b/%b", j, led, press, e[7:4], e[3:0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    edges = 0;
    rst_n = 1'b0;
    btn   = '0;
    mode  = 2'b00;
    @(negedge clk);
    test_reset();
    test_toggle();
    test_glitch();
    test_momentary();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
